// File: rtl/ntt_butterfly_ct_64b_pp.sv
// Cooley-Tukey NTT butterfly (a + b*w, a - b*w) mod q, built around a 12-stage Barrett
// modular multiplier; 13 enabled cycles of latency, one butterfly per enabled cycle.

module ntt_barrett_mulmod_12c (
  input  logic         iClk,
  input  logic         iRstN,
  input  logic         iEn,
  input  logic         iClr,
  input  logic [63:0]  iA,
  input  logic [63:0]  iB,
  input  logic [63:0]  iMod,
  input  logic [6:0]   iK,
  input  logic [127:0] iU,
  output logic [63:0]  oP
);

  logic [63:0]  r_a1, r_b1;
  logic [95:0]  r_ppl, r_pph;
  logic [127:0] r_x3;
  logic [64:0]  r_q1;
  logic [65:0]  r_x4, r_x5, r_x6, r_x7, r_x8, r_x9;
  logic [127:0] r_qul;
  logic [95:0]  r_quh;
  logic [127:0] r_q2;
  logic [64:0]  r_q3;
  logic [65:0]  r_ml;
  logic [33:0]  r_mh;
  logic [65:0]  r_m, r_r, r_r1;
  logic [63:0]  r_p;
  logic [65:0]  w_q66;

  assign w_q66 = {2'b00, iMod};
  assign oP    = r_p;

  // x = a*b; q1 = x >> (k-1); q2 = q1*u; q3 = q2 >> (k+1); r = x - q3*q lies in [0, 3q),
  // so only the low 66 bits of x and q3*q matter and two conditional subtracts finish it.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_a1 <= '0; r_b1 <= '0; r_ppl <= '0; r_pph <= '0; r_x3 <= '0;
      r_q1 <= '0; r_x4 <= '0; r_qul <= '0; r_quh <= '0; r_x5 <= '0;
      r_q2 <= '0; r_x6 <= '0; r_q3 <= '0; r_x7 <= '0; r_ml <= '0;
      r_mh <= '0; r_x8 <= '0; r_m <= '0; r_x9 <= '0; r_r <= '0;
      r_r1 <= '0; r_p <= '0;
    end else if (iClr) begin
      r_a1 <= '0; r_b1 <= '0; r_ppl <= '0; r_pph <= '0; r_x3 <= '0;
      r_q1 <= '0; r_x4 <= '0; r_qul <= '0; r_quh <= '0; r_x5 <= '0;
      r_q2 <= '0; r_x6 <= '0; r_q3 <= '0; r_x7 <= '0; r_ml <= '0;
      r_mh <= '0; r_x8 <= '0; r_m <= '0; r_x9 <= '0; r_r <= '0;
      r_r1 <= '0; r_p <= '0;
    end else if (iEn) begin
      r_a1  <= iA;
      r_b1  <= iB;
      r_ppl <= 96'(r_a1) * 96'(r_b1[31:0]);
      r_pph <= 96'(r_a1) * 96'(r_b1[63:32]);
      r_x3  <= 128'(r_ppl) + {r_pph, 32'd0};
      r_q1  <= 65'(r_x3 >> (iK - 7'd1));
      r_x4  <= r_x3[65:0];
      r_qul <= 128'(r_q1) * 128'(iU[31:0]);
      r_quh <= 96'(r_q1) * iU[127:32];
      r_x5  <= r_x4;
      r_q2  <= r_qul + {r_quh, 32'd0};
      r_x6  <= r_x5;
      r_q3  <= 65'(r_q2 >> (iK + 7'd1));
      r_x7  <= r_x6;
      r_ml  <= 66'(128'(r_q3) * 128'(iMod[31:0]));
      r_mh  <= 34'(r_q3 * 65'(iMod[63:32]));
      r_x8  <= r_x7;
      r_m   <= r_ml + {r_mh, 32'd0};
      r_x9  <= r_x8;
      r_r   <= r_x9 - r_m;
      r_r1  <= (r_r >= w_q66) ? r_r - w_q66 : r_r;
      r_p   <= 64'((r_r1 >= w_q66) ? r_r1 - w_q66 : r_r1);
    end
  end

endmodule

module ntt_butterfly_ct_64b_pp (
  input  logic         iClk,
  input  logic         iRstN,
  input  logic         iEn,
  input  logic         iClr,
  input  logic         iValid,
  input  logic [63:0]  iA,
  input  logic [63:0]  iB,
  input  logic [63:0]  iW,
  input  logic [63:0]  iMod,
  input  logic [6:0]   iK,
  input  logic [127:0] iU,
  output logic         oValid,
  output logic [63:0]  oA,
  output logic [63:0]  oB
);

  localparam int unsigned LAT = 12;

  logic [63:0]    r_a_dl [LAT];
  logic [LAT-1:0] r_v_dl;
  logic           r_ov;
  logic [63:0]    r_oa, r_ob;
  logic [63:0]    w_p, w_a, w_oa, w_ob;
  logic [64:0]    w_sum, w_q65;

  ntt_barrett_mulmod_12c u_mul (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iEn   (iEn),
    .iClr  (iClr),
    .iA    (iB),
    .iB    (iW),
    .iMod  (iMod),
    .iK    (iK),
    .iU    (iU),
    .oP    (w_p)
  );

  assign w_a = r_a_dl[LAT-1];

  always_comb begin
    w_q65 = {1'b0, iMod};
    w_sum = {1'b0, w_a} + {1'b0, w_p};
    w_oa  = 64'((w_sum >= w_q65) ? w_sum - w_q65 : w_sum);
    w_ob  = 64'((w_a >= w_p) ? {1'b0, w_a} - {1'b0, w_p}
                             : {1'b0, w_a} + w_q65 - {1'b0, w_p});
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int unsigned i = 0; i < LAT; i++) r_a_dl[i] <= '0;
      r_v_dl <= '0;
      r_ov   <= 1'b0;
      r_oa   <= '0;
      r_ob   <= '0;
    end else if (iClr) begin
      for (int unsigned i = 0; i < LAT; i++) r_a_dl[i] <= '0;
      r_v_dl <= '0;
      r_ov   <= 1'b0;
      r_oa   <= '0;
      r_ob   <= '0;
    end else if (iEn) begin
      r_a_dl[0] <= iA;
      for (int unsigned i = 1; i < LAT; i++) r_a_dl[i] <= r_a_dl[i-1];
      r_v_dl <= {r_v_dl[LAT-2:0], iValid};
      r_ov   <= r_v_dl[LAT-1];
      r_oa   <= w_oa;
      r_ob   <= w_ob;
    end
  end

  assign oValid = r_ov;
  assign oA     = r_oa;
  assign oB     = r_ob;

endmodule

// File: tb/tb_ntt_butterfly_ct_64b_pp.sv
// Bench for ntt_butterfly_ct_64b_pp: vector table, random streams against a plain modular
// arithmetic model with enabled-cycle arrival tracking, clear and async-reset sequences.

module tb_ntt_butterfly_ct_64b_pp;

  logic         iClk = 1'b0;
  logic         iRstN, iEn, iClr, iValid;
  logic [63:0]  iA, iB, iW, iMod;
  logic [6:0]   iK;
  logic [127:0] iU;
  logic         oValid;
  logic [63:0]  oA, oB;

  always #5 iClk = ~iClk;

  ntt_butterfly_ct_64b_pp dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iEn    (iEn),
    .iClr   (iClr),
    .iValid (iValid),
    .iA     (iA),
    .iB     (iB),
    .iW     (iW),
    .iMod   (iMod),
    .iK     (iK),
    .iU     (iU),
    .oValid (oValid),
    .oA     (oA),
    .oB     (oB)
  );

  localparam logic [63:0] QB = 64'h7FFF_FFFF_FFFF_FFE7;

  typedef struct {
    logic [63:0] ea;
    logic [63:0] eb;
    int unsigned due;
  } exp_t;

  typedef struct {
    logic [63:0] a, b, w, q;
    logic [6:0]  k;
    logic [63:0] ea, eb;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int unsigned ncyc  = 0;
  exp_t        sb[$];
  logic        exp_ov = 1'b0;
  logic [63:0] exp_oa = '0, exp_ob = '0;
  vec_t        vt[8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] calc_u(input logic [63:0] q, input logic [6:0] k);
    int unsigned sh;
    sh = 2 * int'(k);
    return (128'd1 << sh) / 128'(q);
  endfunction

  function automatic logic [63:0] ref_add(input logic [63:0] a, b, w, q);
    logic [127:0] p;
    p = (128'(b) * 128'(w)) % 128'(q);
    return 64'((128'(a) + p) % 128'(q));
  endfunction

  function automatic logic [63:0] ref_sub(input logic [63:0] a, b, w, q);
    logic [127:0] p;
    p = (128'(b) * 128'(w)) % 128'(q);
    return 64'((128'(a) + 128'(q) - p) % 128'(q));
  endfunction

  function automatic logic [63:0] rnd_below(input logic [63:0] q);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r % q;
  endfunction

  task automatic set_mod(input logic [63:0] q, input logic [6:0] k);
    iMod = q;
    iK   = k;
    iU   = calc_u(q, k);
  endtask

  // One clock: advance the model by the edge's effect, then check outputs 1 time unit later.
  task automatic tick();
    logic adv, clr, rst;
    rst = !iRstN;
    clr = iClr;
    adv = iRstN && iEn && !iClr;
    @(posedge iClk);
    #1;
    if (rst || clr || !iRstN) begin
      sb.delete();
      exp_ov = 1'b0;
    end else if (adv) begin
      ncyc++;
      if (sb.size() > 0 && sb[0].due == ncyc) begin
        exp_ov = 1'b1;
        exp_oa = sb[0].ea;
        exp_ob = sb[0].eb;
        void'(sb.pop_front());
      end else begin
        exp_ov = 1'b0;
      end
    end
    chk("oValid", 64'(oValid), 64'(exp_ov));
    if (exp_ov) begin
      chk("oA", oA, exp_oa);
      chk("oB", oB, exp_ob);
    end
  endtask

  task automatic issue(input logic [63:0] a, b, w, ea, eb);
    iA = a; iB = b; iW = w;
    iValid = 1'b1;
    if (iRstN && iEn && !iClr) sb.push_back('{ea: ea, eb: eb, due: ncyc + 13});
    tick();
    iValid = 1'b0;
  endtask

  task automatic issue_rand();
    logic [63:0] a, b, w;
    a = rnd_below(iMod); b = rnd_below(iMod); w = rnd_below(iMod);
    issue(a, b, w, ref_add(a, b, w, iMod), ref_sub(a, b, w, iMod));
  endtask

  task automatic drain();
    repeat (16) tick();
    chk("drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{a: 64'd3,  b: 64'd5,  w: 64'd4,  q: 64'd17, k: 7'd5, ea: 64'd6,  eb: 64'd0};
    vt[1] = '{a: 64'd16, b: 64'd1,  w: 64'd16, q: 64'd17, k: 7'd5, ea: 64'd15, eb: 64'd0};
    vt[2] = '{a: 64'd0,  b: 64'd1,  w: 64'd1,  q: 64'd17, k: 7'd5, ea: 64'd1,  eb: 64'd16};
    vt[3] = '{a: 64'd0,  b: 64'd0,  w: 64'd0,  q: 64'd17, k: 7'd5, ea: 64'd0,  eb: 64'd0};
    vt[4] = '{a: 64'd16, b: 64'd16, w: 64'd16, q: 64'd17, k: 7'd5, ea: 64'd0,  eb: 64'd15};
    vt[5] = '{a: QB - 64'd1, b: QB - 64'd1, w: QB - 64'd1, q: QB, k: 7'd63,
              ea: 64'd0, eb: QB - 64'd2};
    vt[6] = '{a: 64'd0, b: 64'd1, w: QB - 64'd1, q: QB, k: 7'd63, ea: QB - 64'd1, eb: 64'd1};
    vt[7] = '{a: 64'd1, b: 64'd1, w: 64'd1, q: 64'd2, k: 7'd2, ea: 64'd0, eb: 64'd0};

    iRstN = 1'b0; iEn = 1'b0; iClr = 1'b0; iValid = 1'b0;
    iA = '0; iB = '0; iW = '0;
    set_mod(64'd17, 7'd5);
    repeat (3) tick();
    chk("reset_oA", oA, 64'd0);
    chk("reset_oB", oB, 64'd0);
    iRstN = 1'b1;
    iEn   = 1'b1;

    // Directed vectors, one at a time
    for (int i = 0; i < 8; i++) begin
      set_mod(vt[i].q, vt[i].k);
      issue(vt[i].a, vt[i].b, vt[i].w, vt[i].ea, vt[i].eb);
      drain();
    end

    // Back-to-back random stream at the large modulus with two 3-cycle stalls
    set_mod(QB, 7'd63);
    for (int i = 0; i < 20; i++) begin
      if (i == 7 || i == 16) begin
        iEn = 1'b0;
        repeat (3) begin
          iA = rnd_below(QB); iB = rnd_below(QB); iW = rnd_below(QB);
          iValid = 1'b1;
          tick();
        end
        iValid = 1'b0;
        iEn = 1'b1;
      end
      issue_rand();
    end
    drain();

    // Random gaps and random enable at assorted moduli
    for (int m = 0; m < 3; m++) begin
      logic [63:0] q;
      logic [6:0]  k;
      q = {1'b0, $urandom, $urandom} >> ($urandom_range(0, 58));
      if (q < 64'd2) q = 64'd2;
      k = 7'd0;
      for (int b = 0; b < 64; b++) if (q[b]) k = 7'(b + 1);
      set_mod(q, k);
      for (int i = 0; i < 30; i++) begin
        iEn = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) != 0) issue_rand();
        else tick();
      end
      iEn = 1'b1;
      drain();
    end

    // Synchronous clear with results on the outputs and butterflies in flight
    set_mod(64'd17, 7'd5);
    repeat (14) issue(64'd16, 64'd1, 64'd16, 64'd15, 64'd0);
    repeat (4) tick();
    iClr = 1'b1;
    issue(64'd3, 64'd5, 64'd4, 64'd6, 64'd0);
    iClr = 1'b0;
    chk("clr_oA", oA, 64'd0);
    chk("clr_oB", oB, 64'd0);
    drain();

    // Asynchronous reset between edges with 4 butterflies still in flight
    repeat (5) issue(64'd16, 64'd1, 64'd16, 64'd15, 64'd0);
    repeat (8) tick();
    #3;
    iRstN = 1'b0;
    #1;
    chk("arst_oValid", 64'(oValid), 64'd0);
    chk("arst_oA", oA, 64'd0);
    chk("arst_oB", oB, 64'd0);
    sb.delete();
    exp_ov = 1'b0;
    repeat (2) tick();
    iRstN = 1'b1;
    repeat (20) tick();
    issue(64'd3, 64'd5, 64'd4, 64'd6, 64'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
